mult_8x8_seq_ctrl: RTL and testbench



---
 rtl/approx_mult_pkg.sv | 52 +++++
 rtl/mult_8x8_seq_ctrl_mul4x4_sel.sv | 85 ++++++++
 rtl/mult_8x8_seq_ctrl.sv | 109 ++++++++++
 tb/tb_mult_8x8_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// Shared constants for the time-shared 8x8 approximate multiplier:
// variant codes, FSM states, quadrant shifts and config layout.
package approx_mult_pkg;

    localparam int CFG_W = 13;
    localparam int CFG_COMBINE_BIT = 12;

    localparam logic [2:0] VAR_EXACT = 3'b000;
    localparam logic [2:0] VAR_N1    = 3'b001;
    localparam logic [2:0] VAR_N2    = 3'b010;
    localparam logic [2:0] VAR_R1    = 3'b011;
    localparam logic [2:0] VAR_R2    = 3'b100;

    localparam logic [3:0] SHIFT_Q0 = 4'd0;
    localparam logic [3:0] SHIFT_Q1 = 4'd4;
    localparam logic [3:0] SHIFT_Q2 = 4'd4;
    localparam logic [3:0] SHIFT_Q3 = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] quad_shift(input logic [1:0] q);
        logic [3:0] s;
        s = SHIFT_Q0;
        case (q)
            2'd0: s = SHIFT_Q0;
            2'd1: s = SHIFT_Q1;
            2'd2: s = SHIFT_Q2;
            default: s = SHIFT_Q3;
        endcase
        return s;
    endfunction

    function automatic logic [2:0] quad_variant(
        input logic [CFG_W-1:0] cfg,
        input logic [1:0]       q
    );
        logic [2:0] v;
        v = cfg[2:0];
        case (q)
            2'd0: v = cfg[2:0];
            2'd1: v = cfg[5:3];
            2'd2: v = cfg[8:6];
            default: v = cfg[11:9];
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mult_8x8_seq_ctrl_mul4x4_sel.sv
// Combinational 4x4 multiplier slot with selectable variant, plus the
// exact / truncating (N1, N2) / rounding (R1, R2) 4x4 multipliers.
module EX_4x4_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    assign p = a * b;
endmodule

// Truncates the least significant product bit.
module N1_4x4_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [7:0] prod;
    assign prod = a * b;
    assign p = prod & 8'hFE;
endmodule

module N2_4x4_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [7:0] prod;
    assign prod = a * b;
    assign p = prod & 8'hFC;
endmodule

// Round-half-up to a multiple of 2; max 225+1 still fits in 8 bits.
module R1_4x4_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [7:0] sum;
    assign sum = (a * b) + 8'd1;
    assign p = sum & 8'hFE;
endmodule

module R2_4x4_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [7:0] sum;
    assign sum = (a * b) + 8'd2;
    assign p = sum & 8'hFC;
endmodule

module mul4x4_sel
    import approx_mult_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [2:0] variant,
    output logic [7:0] p
);
    logic [7:0] p_ex;
    logic [7:0] p_n1;
    logic [7:0] p_n2;
    logic [7:0] p_r1;
    logic [7:0] p_r2;

    EX_4x4_mul u_ex (.a(x), .b(y), .p(p_ex));
    N1_4x4_mul u_n1 (.a(x), .b(y), .p(p_n1));
    N2_4x4_mul u_n2 (.a(x), .b(y), .p(p_n2));
    R1_4x4_mul u_r1 (.a(x), .b(y), .p(p_r1));
    R2_4x4_mul u_r2 (.a(x), .b(y), .p(p_r2));

    // Reserved codes fall back to the exact product.
    always_comb begin
        p = p_ex;
        case (variant)
            VAR_N1:  p = p_n1;
            VAR_N2:  p = p_n2;
            VAR_R1:  p = p_r1;
            VAR_R2:  p = p_r2;
            default: p = p_ex;
        endcase
    end

endmodule

// File: rtl/mult_8x8_seq_ctrl.sv
// Sequential 8x8 multiplier: one 4x4 slot walks the four quadrants,
// combining partials by addition or shifted OR.
module mult_8x8_seq_ctrl
    import approx_mult_pkg::*;
#(
    parameter logic [12:0] CFG_RESET = 13'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [12:0] cfg_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] r,
    output logic        busy
);

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic [1:0]  quad;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [12:0] cfg_reg;
    logic [12:0] cfg_snap;
    logic [15:0] acc;
    logic [15:0] acc_nxt;
    logic [15:0] part_sh;
    logic [3:0]  x_nib;
    logic [3:0]  y_nib;
    logic [2:0]  var_sel;
    logic [7:0]  prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_MUL;
                end
            end
            ST_MUL: begin
                if (quad == 2'd3) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         cfg_reg <= CFG_RESET;
        else if (cfg_we) cfg_reg <= cfg_data;
    end

    // q1 pairs a-low with b-high, q2 a-high with b-low.
    always_comb begin
        x_nib   = quad[1] ? a_q[7:4] : a_q[3:0];
        y_nib   = quad[0] ? b_q[7:4] : b_q[3:0];
        var_sel = quad_variant(cfg_snap, quad);
        part_sh = {8'h00, prod} << quad_shift(quad);
        if (cfg_snap[CFG_COMBINE_BIT]) acc_nxt = acc | part_sh;
        else                           acc_nxt = acc + part_sh;
    end

    mul4x4_sel u_slot (
        .x      (x_nib),
        .y      (y_nib),
        .variant(var_sel),
        .p      (prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            cfg_snap <= CFG_RESET;
            acc      <= 16'h0000;
            quad     <= 2'd0;
        end else if (accept) begin
            a_q      <= a;
            b_q      <= b;
            cfg_snap <= cfg_reg;
            acc      <= 16'h0000;
            quad     <= 2'd0;
        end else if (state == ST_MUL) begin
            acc      <= acc_nxt;
            quad     <= quad + 2'd1;
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = ~in_ready;
    assign out_valid = (state == ST_DONE);
    assign r         = acc;

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Bench for mult_8x8_seq_ctrl: arithmetic golden model with a per-cycle
// compare process, plus directed vectors with literal expectations.
module tb_mult_8x8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [12:0] cfg_data = 13'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = 8'h0;
    logic [7:0]  b = 8'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] r;
    logic        busy;

    int tests = 0;
    int fails = 0;

    localparam int M_IDLE = 0;
    localparam int M_MUL  = 1;
    localparam int M_DONE = 2;

    always #5 clk = ~clk;

    mult_8x8_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_data (cfg_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .r        (r),
        .busy     (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int approx(input int p, input int v);
        case (v)
            1: return p - (p % 2);
            2: return p - (p % 4);
            3: return ((p + 1) / 2) * 2;
            4: return ((p + 2) / 4) * 4;
            default: return p;
        endcase
    endfunction

    function automatic int model(input int av, input int bv, input int cfg);
        int acc;
        acc = 0;
        for (int q = 0; q < 4; q++) begin
            int an, bn, p, sh;
            an = (q >= 2) ? (av / 16) % 16 : av % 16;
            bn = (q % 2 == 1) ? (bv / 16) % 16 : bv % 16;
            p  = approx(an * bn, (cfg >> (3 * q)) % 8);
            sh = (q == 0) ? 0 : (q == 3) ? 8 : 4;
            if ((cfg >> 12) % 2 == 1) acc = acc | (p << sh);
            else                      acc = acc + (p << sh);
        end
        return acc;
    endfunction

    // Per-cycle reference: phase, pending result and config register.
    int m_state = M_IDLE;
    int m_cnt = 0;
    int m_exp = 0;
    int m_cfg = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_in_ready", int'(in_ready), 1);
                check("rst_out_valid", int'(out_valid), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_r", int'(r), 0);
                m_state = M_IDLE;
                m_cfg = 0;
            end else begin
                check("cyc_in_ready", int'(in_ready), int'(m_state == M_IDLE));
                check("cyc_busy", int'(busy), int'(m_state != M_IDLE));
                check("cyc_out_valid", int'(out_valid), int'(m_state == M_DONE));
                if (m_state == M_DONE) check("cyc_r", int'(r), m_exp);
                case (m_state)
                    M_IDLE: if (in_valid) begin
                        m_exp = model(int'(a), int'(b), m_cfg);
                        m_cnt = 0;
                        m_state = M_MUL;
                    end
                    M_MUL: begin
                        m_cnt++;
                        if (m_cnt == 4) m_state = M_DONE;
                    end
                    default: if (out_ready) m_state = M_IDLE;
                endcase
                if (cfg_we) m_cfg = int'(cfg_data);
            end
        end
    end

    task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
        bit ok;
        ok = 0;
        a = av;
        b = bv;
        in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("accept_timeout", int'(ok), 1);
    endtask

    task automatic wait_done(input string name, input bit lit, input int exp);
        bit ok;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        check({name, "_timeout"}, int'(ok), 1);
        if (lit) check(name, int'(r), exp);
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [12:0] d);
        cfg_we = 1'b1;
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        logic [15:0] held;
        check("pin_ff", model(255, 255, 0), 16'hFE01);
        check("pin_or", model(17, 17, 13'h1000), 16'h0111);
        check("pin_add", model(17, 17, 0), 16'h0121);
        check("pin_snap", model(18, 52, 0), 16'h03A8);
        check("pin_r1", model(7, 7, 3), 16'h0032);
        check("pin_r2", model(7, 7, 4), 16'h0030);
        check("pin_n1", model(19, 53, 1), 16'h03EE);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        start_op(8'hFF, 8'hFF);
        wait_done("full_scale", 1, 16'hFE01);

        write_cfg(13'h1000);
        start_op(8'h11, 8'h11);
        wait_done("or_combine", 1, 16'h0111);
        write_cfg(13'h0000);
        start_op(8'h11, 8'h11);
        wait_done("add_combine", 1, 16'h0121);

        // Backpressure with a competing request held during DONE.
        out_ready = 1'b0;
        start_op(8'h21, 8'h13);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        held = r;
        check("bp_first", int'(held), 16'h0273);
        @(posedge clk);
        #1;
        a = 8'h02;
        b = 8'h03;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid_hold", int'(out_valid), 1);
            check("bp_r_hold", int'(r), int'(held));
            check("bp_not_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        start_op(8'h02, 8'h03);
        wait_done("bp_next", 1, 16'h0006);

        // Config write mid-operation only affects the next operation.
        start_op(8'h12, 8'h34);
        @(posedge clk);
        #1;
        write_cfg(13'h0001);
        wait_done("snap_old", 1, 16'h03A8);
        start_op(8'h13, 8'h35);
        wait_done("snap_new", 1, 16'h03EE);

        // Write on the accept edge: snapshot takes the old value.
        write_cfg(13'h0000);
        cfg_we = 1'b1;
        cfg_data = 13'h0002;
        start_op(8'h0A, 8'h0B);
        cfg_we = 1'b0;
        wait_done("acc_edge_old", 1, 16'h006E);
        start_op(8'h0A, 8'h0B);
        wait_done("acc_edge_new", 1, 16'h006C);

        // Asynchronous reset in the middle of an operation.
        start_op(8'hFF, 8'hFF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_r", int'(r), 0);
        check("mid_rst_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_op(8'h0A, 8'h0B);
        wait_done("post_rst", 1, 16'h006E);

        // Variant sweep: each code on each quadrant, both combine modes.
        for (int m = 0; m < 2; m++) begin
            for (int qd = 0; qd < 4; qd++) begin
                for (int v = 0; v < 8; v++) begin
                    write_cfg(13'((m << 12) | (v << (3 * qd))));
                    start_op(8'hFF, 8'hFF);
                    wait_done("sweep_ff", 0, 0);
                    for (int k = 0; k < 3; k++) begin
                        start_op(8'($urandom_range(255)), 8'($urandom_range(255)));
                        wait_done("sweep_rnd", 0, 0);
                    end
                end
            end
        end

        for (int k = 0; k < 24; k++) begin
            write_cfg(13'($urandom_range(8191)));
            start_op(8'($urandom_range(255)), 8'($urandom_range(255)));
            wait_done("rand_cfg", 0, 0);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
